// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit timing default and the transmit
// launch sequencer state encoding.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular byte FIFO with wrap-bit pointers and a sticky overflow
// flag. The head entry is presented combinationally on rd_data.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]        wr_ptr;
  logic [ADDR_W:0]        rd_ptr;
  logic                   wr_ok;

  // Full blocks writes even when a pop lands on the same edge.
  assign wr_ok = wr_en && !full;

  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A rejected write on the same edge as a clear keeps the flag set.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer feeding the UART transmitter: queues host
// bytes and hands them over one frame at a time using tx_busy/tx_done pacing.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   active
);

  tx_state_e              state;
  tx_state_e              state_nxt;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx_done outside WAIT_DONE is ignored, as is tx_busy inside it.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= '0;
    end else if (pop) begin
      tx_data <= head;
    end
  end

  assign tx_start = (state == START);
  assign active   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter and a byte
// scoreboard checked at every launch.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int BUSY_CYCLES = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              full, empty, overflow;
  logic [ADDR_W:0]   count;
  logic              clr_ovf = 1'b0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy, tx_done, active;

  logic              man_busy = 1'b0;
  logic              man_done = 1'b0;
  logic              m_busy, m_done;
  int                m_cnt;

  int                n_pass = 0;
  int                n_total = 0;
  int                launches = 0;
  logic [7:0]        cur_byte = 8'h00;
  logic [7:0]        sb [$];

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .active   (active)
  );

  always #5 clk = ~clk;

  assign tx_busy = m_busy | man_busy;
  assign tx_done = m_done | man_done;

  // Transmitter model: busy for BUSY_CYCLES after a start, then a done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (tx_start) begin
        m_busy <= 1'b1;
        m_cnt  <= BUSY_CYCLES;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt  <= 0;
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Launch monitor: each tx_start must carry the oldest outstanding byte,
  // and tx_data must stay put for the rest of the frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_start === 1'b1) begin
        launches++;
        chk("sb_has_byte", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          cur_byte = sb.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(cur_byte));
        end
      end else if (active === 1'b1) begin
        chk("tx_hold", 32'(tx_data), 32'(cur_byte));
      end
    end
  end

  task automatic push_wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    sb.push_back(b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && active === 1'b0) break;
    end
    chk(tag, 32'(i < 3000), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int l0;
    int i;

    // Reset state, asserted asynchronously between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_launch", 32'(launches), 32'd0);
    @(posedge clk); #1;

    // Single byte: launch pulse in the cycle after the pop edge.
    push_wr(8'hA5);
    @(negedge clk);
    chk("single_cnt_e", 32'(count), 32'd1);
    chk("single_nostart", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_cnt_e1", 32'(count), 32'd0);
    @(posedge clk); #1;
    drain("single_drain");
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_launches", 32'(launches), 32'd1);

    // Spurious tx_done in IDLE with an empty FIFO.
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    @(negedge clk);
    chk("spur_idle_active", 32'(active), 32'd0);
    chk("spur_idle_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // Burst fill with transmitter held busy, then overflow handling.
    man_busy = 1'b1;
    for (i = 1; i <= 16; i++) push_wr(8'(i));
    @(negedge clk);
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_count", 32'(count), 32'd16);
    chk("busy_hold_idle", 32'(active), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = 8'hFF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = 8'hFF; clr_ovf = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_count2", 32'(count), 32'd16);
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    man_busy = 1'b0;
    k = 0;
    for (i = 0; i < 1000 && k < 16; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        k++;
        chk("burst_dec", 32'(count), 32'(16 - k));
      end
    end
    chk("burst_launched", 32'(k), 32'd16);
    @(posedge clk); #1;
    drain("burst_drain");

    // Simultaneous write and pop at count 5.
    man_busy = 1'b1;
    for (i = 0; i < 5; i++) push_wr(8'h21 + 8'(i));
    @(negedge clk);
    chk("simul_pre", 32'(count), 32'd5);
    @(posedge clk); #1;
    man_busy = 1'b0;
    push_wr(8'h26);
    @(negedge clk);
    chk("simul_count", 32'(count), 32'd5);
    chk("simul_start", 32'(tx_start), 32'd1);
    @(posedge clk); #1;
    drain("simul_drain");

    // Pointer wrap over 40 bytes.
    for (int g = 0; g < 5; g++) begin
      for (int j = 0; j < 8; j++) push_wr(8'h80 + 8'(g * 8 + j));
      drain("wrap_drain");
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // tx_done arriving during START must not end the frame.
    man_busy = 1'b1;
    push_wr(8'h5C);
    man_busy = 1'b0;
    @(posedge clk); #1;
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    @(negedge clk);
    chk("spur_start_active", 32'(active), 32'd1);
    @(posedge clk); #1;
    drain("spur_start_drain");

    // Reset in WAIT_DONE discards queued bytes.
    for (i = 0; i < 3; i++) push_wr(8'hC0 + 8'(i));
    k = 0;
    for (i = 0; i < 100 && k == 0; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) k = 1;
    end
    chk("mid_launch_seen", 32'(k), 32'd1);
    @(posedge clk); #3;
    chk("mid_in_wait", 32'(active), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'd0);
    sb.delete();
    l0 = launches;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_launches", 32'(launches), 32'(l0));
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
